z_writeback_sequencer: RTL and testbench
========================================

# z_writeback_sequencer

Multi-cycle controller that sequences result capture and writeback around the 64-bit Z register. It launches an ALU operation, waits a fixed latency, and steps the Z register's `Z_input`/`Z_Lo_select`/`Z_Hi_select` controls so that both halves are captured. It then drives the bus-source and destination-enable strobes that move Z low into LO (or the general-purpose destination) and Z high into HI. It sits in the control unit between the instruction decoder and the datapath.

## Interface
- `MUL_LATENCY`, default 4: cycles the multiplier needs from `alu_go` to a valid 64-bit result.
- `DIV_LATENCY`, default 34: cycles the divider needs from `alu_go` to a valid 64-bit result.
- `CNT_W`, default 6: latency counter width. Both latencies must be ≥1 and ≤2^CNT_W.

Ports:
- `clk` in 1: sole clock, rising edge.
- `clr` in 1: synchronous, active-high reset. Has priority over all other inputs.
- `start` in 1: request; sampled only in IDLE.
- `op` in 2: operation type. 00 = single-word ALU op, 01 = MUL, 10 = DIV, 11 = reserved and treated as 00. Latched when `start` is accepted.
- `alu_go` out 1: one-cycle launch pulse to the ALU.
- `Z_input`, `Z_Lo_select`, `Z_Hi_select` out 1 each: Z register controls.
- `Zlo_out`, `Zhi_out` out 1 each: bus source selects.
- `Rin` out 1: general-purpose destination write enable.
- `LO_in`, `HI_in` out 1 each: LO and HI register write enables.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: registered one-cycle pulse, set when `start` arrives while `busy`.

## Operation
- States: IDLE, EXEC, CAP_LO, CAP_HI, WB_LO, WB_HI, DONE.
- IDLE with `start`=1:
  - Latch `op`.
  - Load the counter with latency−1 (1 for single-word, so load 0).
  - Go to EXEC.
- EXEC:
  - `alu_go`=1 on the first EXEC cycle only.
  - Counter decrements each cycle.
  - Leave when the counter is 0. EXEC therefore lasts exactly `latency` cycles.
- CAP_LO: `Z_input`=1, `Z_Lo_select`=1.
  - Single-word → WB_LO.
  - MUL/DIV → CAP_HI.
- CAP_HI: `Z_input`=1, `Z_Hi_select`=1, `Z_Lo_select`=0. The Z register gives LO priority, so the two halves are never selected in the same cycle. → WB_LO.
- WB_LO: `Zlo_out`=1. Single-word asserts `Rin`=1 → DONE. MUL/DIV asserts `LO_in`=1 → WB_HI.
- WB_HI: `Zhi_out`=1, `HI_in`=1 → DONE.
- DONE: `done`=1 → IDLE.
- All strobes are Moore outputs decoded from state (plus latched op). Every strobe not listed for a state is 0.
- At most one of `Zlo_out`/`Zhi_out` is high in any cycle; never two bus sources.
- `start` outside IDLE:
  - Ignored, with no effect on state, counter or latched op.
  - `err`=1 in the following cycle.
  - `start` held high continuously while busy pulses `err` every cycle.
- `op` changes after acceptance are ignored.

## Timing
- Reset (`clr`=1 at an edge): next cycle state=IDLE, counter=0, latched op=00, and every output is 0, including `busy`, `done` and `err`.
- `clr` mid-operation aborts immediately: no further `Z_input`, `LO_in`, `HI_in` or `Rin`. Partial Z/LO/HI contents are left as is.
- `clr` and `start` in the same cycle: the reset wins and `start` is dropped.
- Cycle 0 is IDLE with `start`=1.
  - Single-word: EXEC 1, CAP_LO 2, WB_LO 3, DONE 4, IDLE 5 (5 cycles start→idle).
  - MUL (latency 4): EXEC 1–4, CAP_LO 5, CAP_HI 6, WB_LO 7, WB_HI 8, DONE 9, IDLE 10.
  - DIV (latency 34): EXEC 1–34, CAP_LO 35, CAP_HI 36, WB_LO 37, WB_HI 38, DONE 39.
- General rule: `busy` is high from cycle 1 through the DONE cycle inclusive.
- A new `start` is accepted in the first IDLE cycle after DONE. There is no back-to-back acceptance in DONE; `start` there raises `err`.

## Test plan
- Reset: hold `clr` 2 cycles with `start`=1 → all outputs 0, state IDLE. Release; `start` next cycle is accepted (`busy`=1 one cycle later).
- Single-word op=00:
  - `alu_go` in cycle 1.
  - `Z_input`&`Z_Lo_select` in cycle 2.
  - `Zlo_out`&`Rin` in cycle 3.
  - `done` in cycle 4.
  - `LO_in`/`HI_in`/`Zhi_out` never asserted.
  - op=11 gives an identical trace.
- MUL, default parameters:
  - `alu_go` only in cycle 1.
  - CAP_LO 5, CAP_HI 6; `Zlo_out`+`LO_in` 7; `Zhi_out`+`HI_in` 8; `done` 9.
  - Scoreboard with a Z register model fed D=64'h0123_4567_89AB_CDEF: LO=32'h89ABCDEF, HI=32'h01234567.
- DIV with DIV_LATENCY=34 → `done` in cycle 39. Rerun with DIV_LATENCY=1 → `done` in cycle 6.
- `start` pulsed in cycles 3 and 9 of a MUL → `err` in cycles 4 and 10. MUL trace unchanged; op latch unchanged even with `op`=10 on those pulses.
- `clr` asserted in cycle 6 of a MUL (CAP_HI) → cycle 7 all outputs 0, no `LO_in`/`HI_in`. New op=00 `start` in cycle 7 completes with `done` in cycle 11.

Source files
------------

// File: rtl/z_writeback_sequencer.sv
// z_writeback_sequencer: launches an ALU op, waits its latency,
// captures Z halves and writes them back to LO/HI or the GP destination.
module z_writeback_sequencer #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 34,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [1:0] op,
  output logic       alu_go,
  output logic       Z_input,
  output logic       Z_Lo_select,
  output logic       Z_Hi_select,
  output logic       Zlo_out,
  output logic       Zhi_out,
  output logic       Rin,
  output logic       LO_in,
  output logic       HI_in,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_CAP_LO,
    S_CAP_HI,
    S_WB_LO,
    S_WB_HI,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LATENCY - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic             r_first;
  logic             r_err;
  logic             w_wide;
  logic             w_accept;
  logic [1:0]       w_op_n;
  logic [CNT_W-1:0] w_load;

  // Reserved op 11 behaves as a single-word op, so normalise it on latch.
  assign w_op_n   = (op == 2'b11) ? 2'b00 : op;
  assign w_wide   = (r_op == 2'b01) || (r_op == 2'b10);
  assign w_accept = (r_state == S_IDLE) && start;

  // Counter preload is latency-1 so EXEC lasts exactly latency cycles.
  always_comb begin
    w_load = '0;
    unique case (1'b1)
      (w_op_n == 2'b01): w_load = MUL_LD;
      (w_op_n == 2'b10): w_load = DIV_LD;
      default:           w_load = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Latched op, latency counter, first-EXEC flag and err pulse.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt   <= '0;
      r_op    <= 2'b00;
      r_first <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= start && (r_state != S_IDLE);
      if (w_accept) begin
        r_op    <= w_op_n;
        r_cnt   <= w_load;
        r_first <= 1'b1;
      end else if (r_state == S_EXEC) begin
        r_first <= 1'b0;
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Next-state logic and Moore strobe decode.
  always_comb begin
    w_next      = r_state;
    alu_go      = 1'b0;
    Z_input     = 1'b0;
    Z_Lo_select = 1'b0;
    Z_Hi_select = 1'b0;
    Zlo_out     = 1'b0;
    Zhi_out     = 1'b0;
    Rin         = 1'b0;
    LO_in       = 1'b0;
    HI_in       = 1'b0;
    done        = 1'b0;
    busy        = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_EXEC;
      end
      S_EXEC: begin
        alu_go = r_first;
        if (r_cnt == '0) w_next = S_CAP_LO;
      end
      S_CAP_LO: begin
        Z_input     = 1'b1;
        Z_Lo_select = 1'b1;
        w_next      = w_wide ? S_CAP_HI : S_WB_LO;
      end
      S_CAP_HI: begin
        Z_input     = 1'b1;
        Z_Hi_select = 1'b1;
        w_next      = S_WB_LO;
      end
      S_WB_LO: begin
        Zlo_out = 1'b1;
        LO_in   = w_wide;
        Rin     = !w_wide;
        w_next  = w_wide ? S_WB_HI : S_DONE;
      end
      S_WB_HI: begin
        Zhi_out = 1'b1;
        HI_in   = 1'b1;
        w_next  = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign err = r_err;

endmodule

// File: tb/tb_z_writeback_sequencer.sv
// tb_z_writeback_sequencer: randomized bench with a cycle-index
// reference model and a Z/LO/HI datapath scoreboard.
module tb_z_writeback_sequencer;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [11:0] o0, o1;
  logic [11:0] e0, e1;
  int checks = 0;
  int failures = 0;

  localparam logic [63:0] D = 64'h0123_4567_89AB_CDEF;

  always #5 clk = ~clk;

  z_writeback_sequencer dut0 (
    .clk(clk), .clr(clr), .start(start), .op(op),
    .alu_go(o0[11]), .Z_input(o0[10]),
    .Z_Lo_select(o0[9]), .Z_Hi_select(o0[8]),
    .Zlo_out(o0[7]), .Zhi_out(o0[6]), .Rin(o0[5]),
    .LO_in(o0[4]), .HI_in(o0[3]), .busy(o0[2]),
    .done(o0[1]), .err(o0[0])
  );

  z_writeback_sequencer #(.DIV_LATENCY(1)) dut1 (
    .clk(clk), .clr(clr), .start(start), .op(op),
    .alu_go(o1[11]), .Z_input(o1[10]),
    .Z_Lo_select(o1[9]), .Z_Hi_select(o1[8]),
    .Zlo_out(o1[7]), .Zhi_out(o1[6]), .Rin(o1[5]),
    .LO_in(o1[4]), .HI_in(o1[3]), .busy(o1[2]),
    .done(o1[1]), .err(o1[0])
  );

  // Reference model: cycle index k since acceptance (1 = first EXEC).
  logic m_act[2];
  int   m_k[2];
  logic m_wide[2];
  int   m_L[2];
  logic m_err[2];

  function automatic logic [11:0] expv(input logic act, input int k,
                                       input logic wide, input int L);
    logic [11:0] v;
    int d;
    v = '0;
    if (act) begin
      v[2] = 1'b1;
      if (k <= L) begin
        if (k == 1) v[11] = 1'b1;
      end else begin
        d = k - L;
        if (d == 1) begin
          v[10] = 1'b1; v[9] = 1'b1;
        end else if (wide) begin
          case (d)
            2: begin v[10] = 1'b1; v[8] = 1'b1; end
            3: begin v[7] = 1'b1; v[4] = 1'b1; end
            4: begin v[6] = 1'b1; v[3] = 1'b1; end
            default: v[1] = 1'b1;
          endcase
        end else if (d == 2) begin
          v[7] = 1'b1; v[5] = 1'b1;
        end else begin
          v[1] = 1'b1;
        end
      end
    end
    return v;
  endfunction

  always_comb begin
    e0 = expv(m_act[0], m_k[0], m_wide[0], m_L[0]) | {11'b0, m_err[0]};
    e1 = expv(m_act[1], m_k[1], m_wide[1], m_L[1]) | {11'b0, m_err[1]};
  end

  // Z register / bus / LO / HI datapath driven by dut0 strobes.
  logic [31:0] zlo, zhi, lo_r, hi_r;
  always @(posedge clk) begin
    if (clr) begin
      zlo <= '0; zhi <= '0;
    end else begin
      if (o0[10] && o0[9]) zlo <= D[31:0];
      else if (o0[10] && o0[8]) zhi <= D[63:32];
      if (o0[4]) lo_r <= o0[7] ? zlo : (o0[6] ? zhi : 32'h0);
      if (o0[3]) hi_r <= o0[6] ? zhi : (o0[7] ? zlo : 32'h0);
    end
  end

  task automatic tick(input logic s, input logic [1:0] o, input logic c);
    int tot;
    start = s; op = o; clr = c;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (c) begin
        m_act[i] = 1'b0; m_k[i] = 0; m_err[i] = 1'b0;
      end else begin
        m_err[i] = s && m_act[i];
        if (m_act[i]) begin
          tot = m_wide[i] ? m_L[i] + 5 : m_L[i] + 3;
          if (m_k[i] >= tot) m_act[i] = 1'b0;
          else m_k[i] = m_k[i] + 1;
        end else if (s) begin
          m_act[i]  = 1'b1;
          m_k[i]    = 1;
          m_wide[i] = (o == 2'b01) || (o == 2'b10);
          m_L[i]    = (o == 2'b01) ? 4 :
                      (o == 2'b10) ? ((i == 0) ? 34 : 1) : 1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset;
    for (int c = 0; c < 2; c++) begin
      tick(1'b1, 2'b01, 1'b1);
      checks++;
      if (o0 !== 12'h0 || o1 !== 12'h0) begin
        failures++;
        $display("FAIL reset_outputs got=%h/%h want=000", o0, o1);
      end
    end
    tick(1'b0, 2'b00, 1'b0);
    checks++;
    if (o0 !== 12'h0) begin
      failures++;
      $display("FAIL reset_idle got=%h want=000", o0);
    end
    tick(1'b1, 2'b00, 1'b0);
    checks++;
    if (o0[2] !== 1'b1 || o0 !== e0) begin
      failures++;
      $display("FAIL reset_accept got=%h want=%h", o0, e0);
    end
    for (int c = 2; c <= 5; c++) begin
      tick(1'b0, 2'b00, 1'b0);
      checks++;
      if (o0 !== e0) begin
        failures++;
        $display("FAIL reset_trace c=%0d got=%h want=%h", c, o0, e0);
      end
    end
  endtask

  task automatic test_single;
    int dc;
    logic bad;
    logic [1:0] opv;
    for (int p = 0; p < 2; p++) begin
      opv = (p == 0) ? 2'b00 : 2'b11;
      tick(1'b1, opv, 1'b0);
      dc = -1;
      bad = 1'b0;
      for (int c = 1; c <= 6; c++) begin
        checks++;
        if (o0 !== e0) begin
          failures++;
          $display("FAIL single_trace op=%0d c=%0d got=%h want=%h",
                   opv, c, o0, e0);
        end
        if (o0[1] && dc < 0) dc = c;
        bad = bad | o0[4] | o0[3] | o0[6];
        tick(1'b0, 2'($urandom), 1'b0);
      end
      checks++;
      if (dc != 4 || bad !== 1'b0) begin
        failures++;
        $display("FAIL single_done op=%0d done_cyc=%0d hi_strobe=%b want=4/0",
                 opv, dc, bad);
      end
    end
  endtask

  task automatic test_mul;
    int dc;
    for (int r = 0; r < 3; r++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++)
        tick(1'b0, 2'($urandom), 1'b0);
      tick(1'b1, 2'b01, 1'b0);
      dc = -1;
      for (int c = 1; c <= 10; c++) begin
        checks++;
        if (o0 !== e0) begin
          failures++;
          $display("FAIL mul_trace c=%0d got=%h want=%h", c, o0, e0);
        end
        if (o0[1] && dc < 0) dc = c;
        tick(1'b0, 2'($urandom), 1'b0);
      end
      checks++;
      if (dc != 9 || lo_r !== 32'h89ABCDEF || hi_r !== 32'h01234567) begin
        failures++;
        $display("FAIL mul_result done=%0d lo=%h hi=%h want=9/89abcdef/01234567",
                 dc, lo_r, hi_r);
      end
    end
  endtask

  task automatic test_div;
    int dc0, dc1;
    tick(1'b1, 2'b10, 1'b0);
    dc0 = -1; dc1 = -1;
    for (int c = 1; c <= 42; c++) begin
      checks++;
      if (o0 !== e0 || o1 !== e1) begin
        failures++;
        $display("FAIL div_trace c=%0d got=%h/%h want=%h/%h",
                 c, o0, o1, e0, e1);
      end
      if (o0[1] && dc0 < 0) dc0 = c;
      if (o1[1] && dc1 < 0) dc1 = c;
      tick(1'b0, 2'b00, 1'b0);
    end
    checks++;
    if (dc0 != 39 || dc1 != 6) begin
      failures++;
      $display("FAIL div_done got=%0d/%0d want=39/6", dc0, dc1);
    end
  endtask

  task automatic test_err;
    int dc;
    logic [15:0] em;
    logic s;
    tick(1'b1, 2'b01, 1'b0);
    dc = -1; em = '0;
    for (int c = 1; c <= 11; c++) begin
      checks++;
      if (o0 !== e0) begin
        failures++;
        $display("FAIL err_trace c=%0d got=%h want=%h", c, o0, e0);
      end
      if (o0[1] && dc < 0) dc = c;
      if (o0[0]) em[c] = 1'b1;
      s = (c == 3) || (c == 9);
      tick(s, s ? 2'b10 : 2'b01, 1'b0);
    end
    checks++;
    if (em !== 16'h0410 || dc != 9 ||
        lo_r !== 32'h89ABCDEF || hi_r !== 32'h01234567) begin
      failures++;
      $display("FAIL err_pulses mask=%h done=%0d lo=%h hi=%h want=0410/9",
               em, dc, lo_r, hi_r);
    end
  endtask

  task automatic test_clr_abort;
    int dc;
    logic bad;
    tick(1'b1, 2'b01, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (o0 !== e0) begin
        failures++;
        $display("FAIL abort_pre c=%0d got=%h want=%h", c, o0, e0);
      end
      tick(1'b0, 2'b01, (c == 6));
    end
    checks++;
    if (o0 !== 12'h0) begin
      failures++;
      $display("FAIL abort_clear got=%h want=000", o0);
    end
    tick(1'b1, 2'b00, 1'b0);
    dc = -1; bad = 1'b0;
    for (int c = 8; c <= 12; c++) begin
      checks++;
      if (o0 !== e0) begin
        failures++;
        $display("FAIL abort_post c=%0d got=%h want=%h", c, o0, e0);
      end
      if (o0[1] && dc < 0) dc = c;
      bad = bad | o0[4] | o0[3];
      tick(1'b0, 2'b00, 1'b0);
    end
    checks++;
    if (dc != 11 || bad !== 1'b0) begin
      failures++;
      $display("FAIL abort_done done=%0d lohi=%b want=11/0", dc, bad);
    end
  endtask

  task automatic test_random;
    logic s, c;
    for (int n = 0; n < 600; n++) begin
      s = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 50) == 0);
      tick(s, 2'($urandom), c);
      checks++;
      if (o0 !== e0 || o1 !== e1) begin
        failures++;
        $display("FAIL random n=%0d got=%h/%h want=%h/%h",
                 n, o0, o1, e0, e1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_k[i] = 0; m_wide[i] = 1'b0;
      m_L[i] = 1; m_err[i] = 1'b0;
    end
    #1;
    test_reset;
    test_single;
    test_mul;
    test_div;
    test_err;
    test_clr_abort;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
